// File: rtl/ram_arbiter_if.sv
// Bundle of requester, clear and RAM-side signals shared between the arbiter
// (slave) and the requesters/RAM that surround it (master).
interface ram_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mclr_req;
  logic          mclr_ack;
  logic          busy;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_dataIn;
  logic [DW-1:0] ram_dataOut;
  logic          ram_sel, ram_str, ram_ld, ram_clr;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mclr_req, ram_dataOut,
    output ack0, ack1, rdata0, rdata1, mclr_ack, busy,
           ram_address, ram_dataIn, ram_sel, ram_str, ram_ld, ram_clr
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mclr_req, ram_dataOut,
    input  ack0, ack1, rdata0, rdata1, mclr_ack, busy,
           ram_address, ram_dataIn, ram_sel, ram_str, ram_ld, ram_clr
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter and sequencer for the shared single-port data RAM,
// with whole-memory clear taking priority over both ports.
module ram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clr_n,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPT, CLEAR, DONE} state_t;

  state_t        state, state_nxt;
  logic          last;
  logic          gnt;
  logic          is_clr;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          any_req;
  logic          win;

  assign any_req = bus.req0 | bus.req1;
  // Under contention the port that did not win last time goes next.
  assign win     = (bus.req0 && bus.req1) ? ~last : bus.req1;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      gnt       <= 1'b0;
      is_clr    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (bus.mclr_req) begin
          is_clr <= 1'b1;
        end else if (any_req) begin
          is_clr    <= 1'b0;
          gnt       <= win;
          last      <= win;
          lat_we    <= win ? bus.we1    : bus.we0;
          lat_addr  <= win ? bus.addr1  : bus.addr0;
          lat_wdata <= win ? bus.wdata1 : bus.wdata0;
        end
      end
      if (state == CAPT) begin
        if (gnt) rdata1_q <= bus.ram_dataOut;
        else     rdata0_q <= bus.ram_dataOut;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.ram_sel  = 1'b0;
    bus.ram_str  = 1'b0;
    bus.ram_ld   = 1'b0;
    bus.ram_clr  = 1'b0;
    bus.ack0     = 1'b0;
    bus.ack1     = 1'b0;
    bus.mclr_ack = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.mclr_req)  state_nxt = CLEAR;
        else if (any_req)  state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.ram_sel = 1'b1;
        bus.ram_str = lat_we;
        bus.ram_ld  = ~lat_we;
        state_nxt   = lat_we ? DONE : CAPT;
      end
      CAPT: state_nxt = DONE;
      CLEAR: begin
        bus.ram_sel = 1'b1;
        bus.ram_clr = 1'b1;
        state_nxt   = DONE;
      end
      DONE: begin
        bus.mclr_ack = is_clr;
        bus.ack0     = ~is_clr & ~gnt;
        bus.ack1     = ~is_clr &  gnt;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy        = (state != IDLE);
  assign bus.ram_address = lat_addr;
  assign bus.ram_dataIn  = lat_wdata;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a behavioural 4K x 32 RAM, a table of single
// accesses, and hand-written reset, contention and clear sequences.
module tb_ram_arbiter;

  logic clk;
  logic clr_n;
  int   n_tests;
  int   n_fail;
  int   ld_cnt;
  int   clr_cnt;

  ram_arbiter_if #(.AW(12), .DW(32)) bus ();

  ram_arbiter #(.AW(12), .DW(32)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: sampled on the rising edge, read data one cycle after ld.
  logic [31:0] mem [0:4095];
  logic [31:0] dout;
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    dout = 32'h0;
  end
  always @(posedge clk) begin
    if (bus.ram_sel && bus.ram_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
    end else if (bus.ram_sel && bus.ram_str) begin
      mem[bus.ram_address] <= bus.ram_dataIn;
    end
    if (bus.ram_sel && bus.ram_ld) dout <= mem[bus.ram_address];
  end
  assign bus.ram_dataOut = dout;

  always @(negedge clk) begin
    if (bus.ram_ld)  ld_cnt++;
    if (bus.ram_clr) clr_cnt++;
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] r0;
    logic [31:0] r1;
  } vec_t;

  vec_t vec [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " strobes"}, {24'h0, bus.ack0, bus.ack1, bus.mclr_ack, bus.busy,
                              bus.ram_sel, bus.ram_str, bus.ram_ld, bus.ram_clr}, 32'h0);
    check({tag, " ram_address"}, {20'h0, bus.ram_address}, 32'h0);
    check({tag, " ram_dataIn"}, bus.ram_dataIn, 32'h0);
    check({tag, " rdata0"}, bus.rdata0, 32'h0);
    check({tag, " rdata1"}, bus.rdata1, 32'h0);
  endtask

  // Raises one request during an IDLE cycle and returns the number of cycles
  // from the sampling edge to the ack (0 if no ack within the budget).
  task automatic access(input bit p, input bit we, input logic [11:0] a,
                        input logic [31:0] d, output int lat);
    bit got;
    @(negedge clk);
    if (p) begin bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1; end
    else   begin bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1; end
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if ((p && bus.ack1) || (!p && bus.ack0)) begin
        got = 1'b1;
        lat = c;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int order [3];
    int nev;
    int acks0;
    bit rr0;
    int ld0;
    int clr0;
    int mclr_lat;
    int stray;

    n_tests = 0; n_fail = 0; ld_cnt = 0; clr_cnt = 0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.mclr_req = 0;
    clr_n = 1'b0;

    vec[0] = '{1'b1, 1'b1, 12'h00a, 32'h0000_1234, 2, 32'h0,         32'h0};
    vec[1] = '{1'b1, 1'b0, 12'h00a, 32'h0,         3, 32'h0,         32'h0000_1234};
    vec[2] = '{1'b0, 1'b1, 12'hfff, 32'hdead_beef, 2, 32'h0,         32'h0000_1234};
    vec[3] = '{1'b0, 1'b0, 12'hfff, 32'h0,         3, 32'hdead_beef, 32'h0000_1234};
    vec[4] = '{1'b1, 1'b1, 12'h001, 32'h0000_55aa, 2, 32'hdead_beef, 32'h0000_1234};
    vec[5] = '{1'b0, 1'b1, 12'hfff, 32'hffff_ffff, 2, 32'hdead_beef, 32'h0000_1234};
    vec[6] = '{1'b1, 1'b1, 12'h000, 32'h0000_0001, 2, 32'hdead_beef, 32'h0000_1234};
    vec[7] = '{1'b0, 1'b0, 12'hfff, 32'h0,         3, 32'hffff_ffff, 32'h0000_1234};
    vec[8] = '{1'b1, 1'b0, 12'h000, 32'h0,         3, 32'hffff_ffff, 32'h0000_0001};
    vec[9] = '{1'b0, 1'b0, 12'h001, 32'h0,         3, 32'h0000_55aa, 32'h0000_0001};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    clr_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      access(vec[i].port, vec[i].we, vec[i].addr, vec[i].wdata, lat);
      check($sformatf("vec%0d latency", i), lat, vec[i].lat);
      check($sformatf("vec%0d rdata0", i), bus.rdata0, vec[i].r0);
      check($sformatf("vec%0d rdata1", i), bus.rdata1, vec[i].r1);
    end

    // Reset asserted while a port-0 read sits in CAPT.
    @(negedge clk);
    bus.we0 = 1'b0; bus.addr0 = 12'h00a; bus.req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midread busy", {31'h0, bus.busy}, 32'h1);
    clr_n = 1'b0;
    #1;
    check_reset_outputs("midread");
    bus.req0 = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1 || bus.busy) stray++;
    end
    check("midread no ack after reset", stray, 0);

    // Contention straight after reset: expected order 0,1,0.
    order = '{9, 9, 9};
    nev = 0; acks0 = 0; rr0 = 1'b0;
    ld0 = ld_cnt;
    @(negedge clk);
    bus.we0 = 1'b0; bus.addr0 = 12'hfff;
    bus.we1 = 1'b0; bus.addr1 = 12'h000;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int c = 0; c < 60 && nev < 3; c++) begin
      @(negedge clk);
      if (rr0) begin bus.req0 = 1'b1; rr0 = 1'b0; end
      if (bus.ack0) begin
        order[nev] = 0; nev++; acks0++;
        bus.req0 = 1'b0;
        if (acks0 < 2) rr0 = 1'b1;
      end
      if (bus.ack1) begin
        order[nev] = 1; nev++;
        bus.req1 = 1'b0;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("contention grants", nev, 3);
    check("contention order[0]", order[0], 0);
    check("contention order[1]", order[1], 1);
    check("contention order[2]", order[2], 0);
    check("contention ld cycles", ld_cnt - ld0, 3);
    check("contention rdata0", bus.rdata0, 32'hffff_ffff);
    check("contention rdata1", bus.rdata1, 32'h0000_0001);

    // Clear with both ports pending: clear, then port 1 (last was 0), then port 0.
    order = '{9, 9, 9};
    nev = 0; mclr_lat = 0;
    clr0 = clr_cnt;
    @(negedge clk);
    bus.we0 = 1'b0; bus.addr0 = 12'h00a;
    bus.we1 = 1'b0; bus.addr1 = 12'h00a;
    bus.mclr_req = 1'b1; bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int c = 1; c < 60 && nev < 3; c++) begin
      @(negedge clk);
      if (bus.mclr_ack) begin
        order[nev] = 2; nev++; mclr_lat = c;
        bus.mclr_req = 1'b0;
      end
      if (bus.ack0) begin order[nev] = 0; nev++; bus.req0 = 1'b0; end
      if (bus.ack1) begin order[nev] = 1; nev++; bus.req1 = 1'b0; end
    end
    bus.mclr_req = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("clear events", nev, 3);
    check("clear order[0]", order[0], 2);
    check("clear order[1]", order[1], 1);
    check("clear order[2]", order[2], 0);
    check("clear ack latency", mclr_lat, 2);
    check("clear clr cycles", clr_cnt - clr0, 1);
    check("clear rdata0 00a", bus.rdata0, 32'h0);
    check("clear rdata1 00a", bus.rdata1, 32'h0);

    access(1'b0, 1'b0, 12'hfff, 32'h0, lat);
    check("post-clear read fff latency", lat, 3);
    check("post-clear read fff", bus.rdata0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
